op_scheduler: RTL and testbench
===============================

# op_scheduler

Sequencing controller for the ALU datapath's 3-bit opcode / 4-bit select path. It buffers incoming ALU commands in a small FIFO and issues them one at a time to the ALU. Each issue carries a registered opcode, the decoded 4-bit function select and the operands. It waits for completion or timeout, then returns the result through a valid/ready response port. It sits between the command source (control unit or test harness) and the ALU/select datapath.

## Interface
- DEPTH, 4, command FIFO entries (power of two, ≥2)
- DATA_W, 8, operand/result width
- TIMEOUT, 15, max WAIT cycles before error (1..255)

- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept (= !full)
- cmd_op  in  3  opcode
- cmd_a, cmd_b  in  DATA_W  operands
- alu_start  out  1  one-cycle issue pulse
- alu_op  out  3  registered opcode of in-flight command
- alu_sel  out  4  registered decoded select
- alu_a, alu_b  out  DATA_W  registered operands
- alu_done  in  1  ALU completion strobe
- alu_result  in  DATA_W  valid when alu_done=1
- res_valid  out  1  response available
- res_ready  in  1  consumer accepts response
- res_data  out  DATA_W  result (0 on error)
- res_err  out  1  timeout flag for this response
- busy  out  1  state ≠ IDLE
- count  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- Push when cmd_valid & cmd_ready. Push is gated by !full only; a same-cycle pop does not free a slot for a push while full.
- Push and pop in the same non-full cycle: both occur and count is unchanged.
- FSM states and transitions:
  - IDLE → ISSUE: on count>0. Pops the head and registers alu_op, alu_a, alu_b and alu_sel.
  - ISSUE: alu_start=1 for exactly one cycle, then → WAIT. The WAIT counter clears to 0.
  - WAIT: alu_done=1 → latch alu_result into res_data, res_err=0, → RESP. Otherwise the counter increments. When counter==TIMEOUT-1 without done: res_data=0, res_err=1, → RESP.
  - RESP: res_valid=1. res_data and res_err are held stable until res_valid & res_ready. On that handshake: → ISSUE directly with the next head popped if count>0, else → IDLE.
- alu_sel decode, with op = {o2,o1,o0}:
  - sel[3] = ~o2 & ~o1
  - sel[2] = ~o0
  - sel[1] = o1 & o0
  - sel[0] = o2 & o0
- alu_done outside WAIT is ignored; it is not stored and not counted.
- alu_op, alu_sel, alu_a and alu_b hold their values from pop until the next pop.
- Reset mid-operation:
  - FIFO flushed, FSM → IDLE, counter cleared.
  - The in-flight result is discarded; a later alu_done is ignored in IDLE.

## Timing
- Reset values: cmd_ready=1, alu_start=0, alu_op=0, alu_sel=0, alu_a=alu_b=0, res_valid=0, res_data=0, res_err=0, busy=0, count=0.
- Accept at edge t into an empty FIFO, FSM in IDLE:
  - pop at edge t+1
  - alu_start high in cycle t+1..t+2
  - WAIT from edge t+2
- alu_done sampled at WAIT edge w → res_valid high from edge w+1.
- Back-to-back with the FIFO non-empty: RESP handshake at edge h → alu_start in cycle h..h+1 (no IDLE bubble).
- Timeout: res_valid rises exactly TIMEOUT+1 cycles after the ISSUE cycle's rising edge.
- cmd_ready and count are registered-state-derived only; no combinational path from cmd_valid or res_ready.

## Structure
- Shared package alu_pkg:
  - opcode typedef (3-bit)
  - select typedef (4-bit)
  - state enum {IDLE, ISSUE, WAIT, RESP}
  - decode function implementing the sel equations, reused by the bench model.
- One sub-module: op_fifo, a synchronous DEPTH×(3+2·DATA_W) FIFO with push/pop/full/empty/count. The FSM, decode registers and timeout counter stay in op_scheduler.

## Test plan
- Reset then single op=3'b011, a=8'h12, b=8'h05:
  - alu_start 2 cycles after accept, alu_sel=4'b0010, alu_op=3, alu_a=8'h12, alu_b=8'h05.
  - alu_done with result 8'h17 → res_data=8'h17, res_err=0, res_valid held until res_ready.
- Decode sweep, op 0..7 → alu_sel = 1100, 1000, 0100, 0010, 0100, 0001, 0100, 0011.
- Push 5 commands with res_ready=1 and alu_done 1 cycle after each alu_start:
  - count reaches 4, cmd_ready=0 while full.
  - The 5th is accepted only after a pop; responses return in FIFO order with no IDLE gap between them.
- Withhold alu_done:
  - res_valid rises 16 cycles after the ISSUE edge with res_data=0, res_err=1.
  - A late alu_done in RESP is ignored.
- Hold res_ready=0 for 10 cycles in RESP: res_data and res_err stable, no new alu_start, FIFO keeps accepting up to full.
- Assert rst during WAIT with 2 entries queued: next cycle count=0, busy=0, res_valid=0, all outputs at reset values; a subsequent alu_done produces no response.

Source files
------------

// File: rtl/op_scheduler_pkg.sv
// Shared types for the ALU command path: opcode/select widths, scheduler states
// and the opcode-to-function-select decode.
package alu_pkg;

   typedef logic [2:0] opcode_t;
   typedef logic [3:0] select_t;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   function automatic select_t decode_sel(input opcode_t op);
      select_t sel;
      sel[3] = ~op[2] & ~op[1];
      sel[2] = ~op[0];
      sel[1] = op[1] & op[0];
      sel[0] = op[2] & op[0];
      return sel;
   endfunction

endpackage

// File: rtl/op_scheduler_if.sv
// Command, ALU-issue and response signals of the op scheduler, bundled.
// master = scheduler side, slave = command source / ALU / response consumer side.
interface op_scheduler_if #(
   parameter int DATA_W = 8
);
   import alu_pkg::*;

   logic              cmd_valid;
   logic              cmd_ready;
   opcode_t           cmd_op;
   logic [DATA_W-1:0] cmd_a;
   logic [DATA_W-1:0] cmd_b;

   logic              alu_start;
   opcode_t           alu_op;
   select_t           alu_sel;
   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic              alu_done;
   logic [DATA_W-1:0] alu_result;

   logic              res_valid;
   logic              res_ready;
   logic [DATA_W-1:0] res_data;
   logic              res_err;

   modport master (
      input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_done, alu_result, res_ready,
      output cmd_ready, alu_start, alu_op, alu_sel, alu_a, alu_b,
             res_valid, res_data, res_err
   );

   modport slave (
      output cmd_valid, cmd_op, cmd_a, cmd_b, alu_done, alu_result, res_ready,
      input  cmd_ready, alu_start, alu_op, alu_sel, alu_a, alu_b,
             res_valid, res_data, res_err
   );

endinterface

// File: rtl/op_scheduler_fifo.sv
// Synchronous command FIFO; push is refused while full even if a pop happens
// in the same cycle, so full/ready depend on registered state only.
module op_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 19
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic [W-1:0]           din,
   output logic [W-1:0]           dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/op_scheduler.sv
// Issues buffered ALU commands one at a time, waits for done or timeout and
// returns each result through a valid/ready response port.
module op_scheduler
   import alu_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 15
) (
   input  logic                   clk,
   input  logic                   rst,
   op_scheduler_if.master         bus,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] count
);
   localparam int         ENTRY_W  = 3 + 2*DATA_W;
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_t             state;
   state_t             state_n;
   logic               fifo_pop;
   logic               fifo_full;
   logic               fifo_empty;
   logic [ENTRY_W-1:0] head;
   opcode_t            head_op;
   logic [DATA_W-1:0]  head_a;
   logic [DATA_W-1:0]  head_b;
   logic [7:0]         wait_cnt;
   logic               tmo;

   opcode_t            op_p0;
   select_t            sel_p0;
   logic [DATA_W-1:0]  a_p0;
   logic [DATA_W-1:0]  b_p0;
   logic [DATA_W-1:0]  res_data_p1;
   logic               res_err_p1;

   assign {head_op, head_a, head_b} = head;
   assign tmo = (wait_cnt == TMO_LAST);

   op_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (bus.cmd_valid),
      .pop   (fifo_pop),
      .din   ({bus.cmd_op, bus.cmd_a, bus.cmd_b}),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (count)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // Next state and pop; a RESP handshake with work queued goes straight to ISSUE.
   always_comb begin
      state_n  = state;
      fifo_pop = 1'b0;
      unique case (state)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               state_n  = ISSUE;
            end
         end
         ISSUE: state_n = WAIT;
         WAIT: begin
            if (bus.alu_done || tmo) state_n = RESP;
         end
         RESP: begin
            if (bus.res_ready) begin
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  state_n  = ISSUE;
               end else begin
                  state_n  = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Issue stage: registered command, held from one pop to the next
   always_ff @(posedge clk) begin
      if (rst) begin
         op_p0  <= '0;
         sel_p0 <= '0;
         a_p0   <= '0;
         b_p0   <= '0;
      end else if (fifo_pop) begin
         op_p0  <= head_op;
         sel_p0 <= decode_sel(head_op);
         a_p0   <= head_a;
         b_p0   <= head_b;
      end
   end

   // Response stage: done is only observed in WAIT, so late strobes never land here
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt    <= '0;
         res_data_p1 <= '0;
         res_err_p1  <= 1'b0;
      end else begin
         if (state == ISSUE)     wait_cnt <= '0;
         else if (state == WAIT) wait_cnt <= wait_cnt + 8'd1;
         if (state == WAIT) begin
            if (bus.alu_done) begin
               res_data_p1 <= bus.alu_result;
               res_err_p1  <= 1'b0;
            end else if (tmo) begin
               res_data_p1 <= '0;
               res_err_p1  <= 1'b1;
            end
         end
      end
   end

   assign bus.cmd_ready = ~fifo_full;
   assign bus.alu_start = (state == ISSUE);
   assign bus.alu_op    = op_p0;
   assign bus.alu_sel   = sel_p0;
   assign bus.alu_a     = a_p0;
   assign bus.alu_b     = b_p0;
   assign bus.res_valid = (state == RESP);
   assign bus.res_data  = res_data_p1;
   assign bus.res_err   = res_err_p1;
   assign busy          = (state != IDLE);

endmodule

// File: tb/tb_op_scheduler.sv
// Directed bench for op_scheduler: single op, decode sweep, full FIFO with
// back-to-back issue, timeout, response back-pressure and mid-operation reset.
module tb_op_scheduler;
   import alu_pkg::*;

   localparam int DEPTH   = 4;
   localparam int DATA_W  = 8;
   localparam int TIMEOUT = 15;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       busy;
   logic [2:0] count;
   int         n_cmp = 0;
   int         n_bad = 0;

   op_scheduler_if #(.DATA_W(DATA_W)) bus ();

   op_scheduler #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .clk   (clk),
      .rst   (rst),
      .bus   (bus),
      .busy  (busy),
      .count (count)
   );

   always #5 clk = ~clk;

   // hand-decoded selects for op 0..7
   logic [3:0] sel_tbl [8] = '{4'b1100, 4'b1000, 4'b0100, 4'b0010,
                               4'b0100, 4'b0001, 4'b0100, 4'b0011};

   logic [2:0] q_op  [5] = '{3'd2, 3'd7, 3'd0, 3'd5, 3'd6};
   logic [7:0] q_a   [5] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54};
   logic [7:0] q_b   [5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
   logic [7:0] q_res [5] = '{8'h81, 8'h82, 8'h83, 8'h84, 8'h85};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      bus.cmd_op    = op;
      bus.cmd_a     = a;
      bus.cmd_b     = b;
      bus.cmd_valid = 1'b1;
   endtask

   task automatic sweep_op(input logic [2:0] op);
      push_cmd(op, 8'(op) + 8'h40, 8'h07);
      tick();
      bus.cmd_valid = 1'b0;
      tick();
      chk($sformatf("sweep_start_op%0d", op), 32'(bus.alu_start), 1);
      chk($sformatf("sweep_sel_op%0d", op), 32'(bus.alu_sel), 32'(sel_tbl[op]));
      tick();
      bus.alu_done   = 1'b1;
      bus.alu_result = 8'(op) + 8'hC0;
      tick();
      bus.alu_done = 1'b0;
      chk($sformatf("sweep_res_op%0d", op), 32'(bus.res_data), 32'(op) + 32'hC0);
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
      chk($sformatf("sweep_idle_op%0d", op), 32'(busy), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no summary, want finish before time limit");
      $fatal(1);
   end

   initial begin
      int k;
      int rise;
      logic acc;

      bus.cmd_valid  = 1'b0;
      bus.cmd_op     = '0;
      bus.cmd_a      = '0;
      bus.cmd_b      = '0;
      bus.alu_done   = 1'b0;
      bus.alu_result = '0;
      bus.res_ready  = 1'b0;

      // reset values
      tick();
      tick();
      chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);
      chk("rst_alu_start", 32'(bus.alu_start), 0);
      chk("rst_alu_op",    32'(bus.alu_op), 0);
      chk("rst_alu_sel",   32'(bus.alu_sel), 0);
      chk("rst_res_valid", 32'(bus.res_valid), 0);
      chk("rst_res_data",  32'(bus.res_data), 0);
      chk("rst_busy",      32'(busy), 0);
      chk("rst_count",     32'(count), 0);
      rst = 1'b0;

      // single op 3 : 0x12, 0x05 -> 0x17
      push_cmd(3'd3, 8'h12, 8'h05);
      tick();
      bus.cmd_valid = 1'b0;
      chk("s1_count",   32'(count), 1);
      chk("s1_nostart", 32'(bus.alu_start), 0);
      tick();
      chk("s1_start", 32'(bus.alu_start), 1);
      chk("s1_op",    32'(bus.alu_op), 3);
      chk("s1_sel",   32'(bus.alu_sel), 32'b0010);
      chk("s1_a",     32'(bus.alu_a), 32'h12);
      chk("s1_b",     32'(bus.alu_b), 32'h05);
      tick();
      chk("s1_start_low", 32'(bus.alu_start), 0);
      bus.alu_done   = 1'b1;
      bus.alu_result = 8'h17;
      tick();
      bus.alu_done = 1'b0;
      chk("s1_res_valid", 32'(bus.res_valid), 1);
      chk("s1_res_data",  32'(bus.res_data), 32'h17);
      chk("s1_res_err",   32'(bus.res_err), 0);
      tick();
      chk("s1_res_held", 32'(bus.res_valid), 1);
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
      chk("s1_res_gone", 32'(bus.res_valid), 0);
      chk("s1_idle",     32'(busy), 0);

      for (int op = 0; op < 8; op++) sweep_op(3'(op));

      // back-pressure in RESP while the FIFO fills
      push_cmd(3'd1, 8'h0F, 8'hF0);
      tick();
      bus.cmd_valid = 1'b0;
      tick();
      tick();
      bus.alu_done   = 1'b1;
      bus.alu_result = 8'hA5;
      tick();
      bus.alu_done = 1'b0;
      chk("bp_res_valid", 32'(bus.res_valid), 1);
      k = 0;
      for (int i = 0; i < 10; i++) begin
         if (k < 5) push_cmd(q_op[k], q_a[k], q_b[k]);
         else       bus.cmd_valid = 1'b0;
         acc = bus.cmd_valid & bus.cmd_ready;
         tick();
         if (acc) k++;
         chk("bp_hold_data",  32'(bus.res_data), 32'hA5);
         chk("bp_hold_err",   32'(bus.res_err), 0);
         chk("bp_no_start",   32'(bus.alu_start), 0);
      end
      chk("bp_full_count", 32'(count), 4);
      chk("bp_full_ready", 32'(bus.cmd_ready), 0);

      // release: pop while full must not admit the 5th command in that cycle
      bus.res_ready = 1'b1;
      tick();
      chk("b2b_pop_count", 32'(count), 3);
      chk("b2b_ready",     32'(bus.cmd_ready), 1);
      for (int j = 0; j < 5; j++) begin
         chk($sformatf("b2b_start%0d", j), 32'(bus.alu_start), 1);
         chk($sformatf("b2b_op%0d", j),    32'(bus.alu_op), 32'(q_op[j]));
         chk($sformatf("b2b_sel%0d", j),   32'(bus.alu_sel), 32'(sel_tbl[q_op[j]]));
         chk($sformatf("b2b_a%0d", j),     32'(bus.alu_a), 32'(q_a[j]));
         tick();
         if (j == 0) begin
            bus.cmd_valid = 1'b0;
            chk("b2b_refill_count", 32'(count), 4);
         end
         bus.alu_done   = 1'b1;
         bus.alu_result = q_res[j];
         tick();
         bus.alu_done = 1'b0;
         chk($sformatf("b2b_valid%0d", j), 32'(bus.res_valid), 1);
         chk($sformatf("b2b_data%0d", j),  32'(bus.res_data), 32'(q_res[j]));
         tick();
         chk($sformatf("b2b_busy%0d", j),  32'(busy), (j < 4) ? 1 : 0);
         chk($sformatf("b2b_count%0d", j), 32'(count), (j < 4) ? 32'(3 - j) : 0);
      end
      bus.res_ready = 1'b0;

      // timeout: res_valid 16 cycles after the ISSUE edge, then a late done is ignored
      push_cmd(3'd5, 8'h33, 8'h44);
      tick();
      bus.cmd_valid = 1'b0;
      tick();
      chk("tmo_start", 32'(bus.alu_start), 1);
      rise = 0;
      for (int c = 1; c <= 24 && rise == 0; c++) begin
         tick();
         if (bus.res_valid) rise = c;
      end
      chk("tmo_latency", 32'(rise), 16);
      chk("tmo_data",    32'(bus.res_data), 0);
      chk("tmo_err",     32'(bus.res_err), 1);
      bus.alu_done   = 1'b1;
      bus.alu_result = 8'hFF;
      tick();
      bus.alu_done = 1'b0;
      chk("late_valid", 32'(bus.res_valid), 1);
      chk("late_data",  32'(bus.res_data), 0);
      chk("late_err",   32'(bus.res_err), 1);
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
      chk("tmo_idle", 32'(busy), 0);

      // reset during WAIT with two entries queued
      push_cmd(3'd7, 8'hFF, 8'hEE);
      tick();
      push_cmd(3'd6, 8'h11, 8'h22);
      tick();
      push_cmd(3'd4, 8'h33, 8'h44);
      tick();
      bus.cmd_valid = 1'b0;
      chk("mid_busy",  32'(busy), 1);
      chk("mid_count", 32'(count), 2);
      chk("mid_op",    32'(bus.alu_op), 7);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mrst_count",     32'(count), 0);
      chk("mrst_busy",      32'(busy), 0);
      chk("mrst_res_valid", 32'(bus.res_valid), 0);
      chk("mrst_cmd_ready", 32'(bus.cmd_ready), 1);
      chk("mrst_alu_start", 32'(bus.alu_start), 0);
      chk("mrst_alu_op",    32'(bus.alu_op), 0);
      chk("mrst_alu_sel",   32'(bus.alu_sel), 0);
      chk("mrst_alu_a",     32'(bus.alu_a), 0);
      chk("mrst_alu_b",     32'(bus.alu_b), 0);
      chk("mrst_res_data",  32'(bus.res_data), 0);
      chk("mrst_res_err",   32'(bus.res_err), 0);
      bus.alu_done   = 1'b1;
      bus.alu_result = 8'h55;
      tick();
      bus.alu_done = 1'b0;
      tick();
      tick();
      chk("post_rst_no_resp", 32'(bus.res_valid), 0);
      chk("post_rst_idle",    32'(busy), 0);
      chk("post_rst_data",    32'(bus.res_data), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
